// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write command into the address/data byte sequence run by
// i2c_master_single_byte. Define I2C_SEQ_BUSY_TIMEOUT_EN to add a per-byte busy timeout.
module i2c_reg_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR   = 7'h50,
  parameter int unsigned START_WAIT   = 8,
  parameter int unsigned BUSY_TIMEOUT = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_rd,
  input  logic [7:0] i_cmd_reg,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_error,
  output logic       o_m_enable,
  output logic [6:0] o_m_slave_addr,
  output logic       o_m_wr_start,
  output logic       o_m_rd_start,
  output logic [7:0] o_m_wr_byte,
  input  logic       i_m_busy,
  input  logic [7:0] i_m_rd_byte,
  input  logic       i_m_error
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  localparam logic [7:0] START_WAIT_C = 8'(START_WAIT);

  // The wait counter is 8 bits wide, so a larger start window cannot be honoured.
  if (START_WAIT > 255 || BUSY_TIMEOUT == 0) begin : g_bad_param
    $error("i2c_reg_sequencer: START_WAIT must be <= 255 and BUSY_TIMEOUT nonzero");
  end

  state_t     state;
  state_t     state_next;
  logic       cmd_rd;
  logic [7:0] cmd_wdata;
  logic       step;
  logic [7:0] wr_byte;
  logic [7:0] wait_cnt;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       ready;
  logic       enable;

  logic       accept;
  logic       start_miss;
  logic       byte_done;
  logic       byte_fail;
  logic       timeout;

`ifdef I2C_SEQ_BUSY_TIMEOUT_EN
  localparam logic [15:0] BUSY_LIMIT = 16'(BUSY_TIMEOUT - 1);
  logic [15:0] busy_cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written below gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    start_miss = 1'b0;
    byte_done  = 1'b0;
    byte_fail  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (i_cmd_valid && ready) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (i_m_busy) begin
          state_next = WAIT_DONE;
        end else if (wait_cnt >= START_WAIT_C) begin
          start_miss = 1'b1;
          state_next = RESP;
        end
      end
      WAIT_DONE: begin
        if (!i_m_busy) begin
          if (i_m_error) begin
            byte_fail  = 1'b1;
            state_next = RESP;
          end else begin
            byte_done = 1'b1;
            if (step) state_next = RESP;
            else      state_next = ISSUE;
          end
        end
`ifdef I2C_SEQ_BUSY_TIMEOUT_EN
        else if (busy_cnt >= BUSY_LIMIT) begin
          timeout    = 1'b1;
          state_next = RESP;
        end
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cmd_rd    <= 1'b0;
      cmd_wdata <= '0;
      step      <= 1'b0;
      wr_byte   <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      ready     <= 1'b0;
      enable    <= 1'b0;
    end else begin
      // Registered so both read 0 throughout reset and rise on the first edge after.
      ready  <= (state_next == IDLE);
      enable <= !timeout;

      if (accept) begin
        cmd_rd    <= i_cmd_rd;
        cmd_wdata <= i_cmd_wdata;
        wr_byte   <= i_cmd_reg;
        step      <= 1'b0;
        rsp_rdata <= '0;
        rsp_error <= 1'b0;
      end

      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT_BUSY && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (start_miss || byte_fail || timeout) rsp_error <= 1'b1;

      if (byte_done) begin
        if (!step) begin
          step <= 1'b1;
          if (!cmd_rd) wr_byte <= cmd_wdata;
        end else if (cmd_rd) begin
          rsp_rdata <= i_m_rd_byte;
        end
      end
    end
  end

`ifdef I2C_SEQ_BUSY_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                   busy_cnt <= '0;
    else if (state != WAIT_DONE)  busy_cnt <= '0;
    else if (busy_cnt != 16'hFFFF) busy_cnt <= busy_cnt + 16'd1;
  end
`endif

  assign o_cmd_ready    = ready;
  assign o_m_enable     = enable;
  assign o_m_slave_addr = SLAVE_ADDR;
  assign o_m_wr_byte    = wr_byte;
  assign o_m_wr_start   = (state == ISSUE) && !(step && cmd_rd);
  assign o_m_rd_start   = (state == ISSUE) && step && cmd_rd;
  assign o_rsp_valid    = (state == RESP);
  assign o_rsp_rdata    = rsp_rdata;
  assign o_rsp_error    = rsp_error;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer: a behavioural master answers start pulses and a
// vector table plus hand-written sequences check responses, bytes and cycle timing.
module tb_i2c_reg_sequencer;

  localparam int START_WAIT = 8;

  logic       clk;
  logic       i_rst;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic       i_cmd_rd;
  logic [7:0] i_cmd_reg;
  logic [7:0] i_cmd_wdata;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_rdata;
  logic       o_rsp_error;
  logic       o_m_enable;
  logic [6:0] o_m_slave_addr;
  logic       o_m_wr_start;
  logic       o_m_rd_start;
  logic [7:0] o_m_wr_byte;
  logic       i_m_busy;
  logic [7:0] i_m_rd_byte;
  logic       i_m_error;

  i2c_reg_sequencer #(
    .SLAVE_ADDR  (7'h50),
    .START_WAIT  (START_WAIT),
    .BUSY_TIMEOUT(65535)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_rd      (i_cmd_rd),
    .i_cmd_reg     (i_cmd_reg),
    .i_cmd_wdata   (i_cmd_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_error   (o_rsp_error),
    .o_m_enable    (o_m_enable),
    .o_m_slave_addr(o_m_slave_addr),
    .o_m_wr_start  (o_m_wr_start),
    .o_m_rd_start  (o_m_rd_start),
    .o_m_wr_byte   (o_m_wr_byte),
    .i_m_busy      (i_m_busy),
    .i_m_rd_byte   (i_m_rd_byte),
    .i_m_error     (i_m_error)
  );

  typedef struct {
    logic       rd;
    logic [7:0] rg;
    logic [7:0] wd;
    int         blen;
    int         err_on;
    logic       nobusy;
    logic [7:0] rdat;
    logic [7:0] x_rdata;
    logic       x_err;
    int         x_starts;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // master model configuration and observation log
  int         busy_len = 4;
  int         err_on   = 0;
  logic       no_busy  = 1'b0;
  logic [7:0] rd_data  = 8'h00;
  int         cmd_starts = 0;
  logic       st_kind [8];
  logic [7:0] st_byte [8];
  int         st_cycle[8];
  int         drop_cyc[8];

  int         cyc = 0;
  int         rsp_cnt = 0;
  int         rsp_cyc = 0;
  logic [7:0] rsp_rdata_s = 8'h00;
  logic       rsp_err_s = 1'b0;
  int         acc_cyc = 0;
  logic       got_rsp = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural master: busy for busy_len cycles after each start pulse.
  initial begin
    int left;
    left        = 0;
    i_m_busy    = 1'b0;
    i_m_error   = 1'b0;
    i_m_rd_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        i_m_busy = 1'b0;
        left     = 0;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          i_m_busy    = 1'b0;
          i_m_error   = (err_on == cmd_starts);
          i_m_rd_byte = rd_data;
          drop_cyc[cmd_starts-1] = cyc;
        end
      end else if (o_m_wr_start || o_m_rd_start) begin
        st_kind[cmd_starts]  = o_m_rd_start;
        st_byte[cmd_starts]  = o_m_wr_byte;
        st_cycle[cmd_starts] = cyc;
        cmd_starts++;
        i_m_error = 1'b0;
        if (!no_busy) begin
          i_m_busy = 1'b1;
          left     = busy_len;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (o_rsp_valid) begin
      rsp_cnt++;
      rsp_cyc     = cyc;
      rsp_rdata_s = o_rsp_rdata;
      rsp_err_s   = o_rsp_error;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!o_cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", o_cmd_ready, 1);
  endtask

  task automatic wait_rsp(input int target);
    int k;
    k = 0;
    while (rsp_cnt < target && k < 1000) begin
      @(posedge clk);
      k++;
    end
    got_rsp = (rsp_cnt >= target);
  endtask

  task automatic wait_starts(input int target);
    int k;
    k = 0;
    while (cmd_starts < target && k < 1000) begin
      @(posedge clk);
      k++;
    end
    check("start_seen", cmd_starts >= target, 1);
  endtask

  task automatic run_cmd(input logic rd, input logic [7:0] rg, input logic [7:0] wd);
    int n0;
    n0 = rsp_cnt;
    @(negedge clk);
    wait_ready();
    cmd_starts  = 0;
    i_cmd_valid = 1'b1;
    i_cmd_rd    = rd;
    i_cmd_reg   = rg;
    i_cmd_wdata = wd;
    acc_cyc     = cyc;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    wait_rsp(n0 + 1);
  endtask

  initial begin
    vec_t vecs[7];
    int   n0;
    int   rsp_a;

    vecs[0] = '{rd:0, rg:8'h12, wd:8'hAC, blen:20, err_on:0, nobusy:0, rdat:8'h00, x_rdata:8'h00, x_err:0, x_starts:2};
    vecs[1] = '{rd:1, rg:8'h34, wd:8'h00, blen:20, err_on:0, nobusy:0, rdat:8'h5A, x_rdata:8'h5A, x_err:0, x_starts:2};
    vecs[2] = '{rd:0, rg:8'h40, wd:8'h11, blen:5,  err_on:1, nobusy:0, rdat:8'h00, x_rdata:8'h00, x_err:1, x_starts:1};
    vecs[3] = '{rd:1, rg:8'h77, wd:8'h00, blen:5,  err_on:2, nobusy:0, rdat:8'hEE, x_rdata:8'h00, x_err:1, x_starts:2};
    vecs[4] = '{rd:0, rg:8'h08, wd:8'h09, blen:0,  err_on:0, nobusy:1, rdat:8'h00, x_rdata:8'h00, x_err:1, x_starts:1};
    vecs[5] = '{rd:1, rg:8'h00, wd:8'h00, blen:2,  err_on:0, nobusy:0, rdat:8'hFF, x_rdata:8'hFF, x_err:0, x_starts:2};
    vecs[6] = '{rd:0, rg:8'hFF, wd:8'h00, blen:3,  err_on:2, nobusy:0, rdat:8'h00, x_rdata:8'h00, x_err:1, x_starts:2};

    i_rst       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_rd    = 1'b0;
    i_cmd_reg   = 8'h00;
    i_cmd_wdata = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready",    o_cmd_ready,    0);
    check("rst_enable",   o_m_enable,     0);
    check("rst_wr_start", o_m_wr_start,   0);
    check("rst_rsp",      o_rsp_valid,    0);
    check("rst_wr_byte",  o_m_wr_byte,    0);
    check("rst_addr",     o_m_slave_addr, 7'h50);
    i_rst = 1'b1;
    @(negedge clk);
    check("rel_ready",  o_cmd_ready, 1);
    check("rel_enable", o_m_enable,  1);

    for (int i = 0; i < 7; i++) begin
      busy_len = vecs[i].blen;
      err_on   = vecs[i].err_on;
      no_busy  = vecs[i].nobusy;
      rd_data  = vecs[i].rdat;
      n0       = rsp_cnt;
      run_cmd(vecs[i].rd, vecs[i].rg, vecs[i].wd);
      check($sformatf("v%0d_rsp_seen", i), got_rsp, 1);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_rsp_count", i), rsp_cnt - n0, 1);
      check($sformatf("v%0d_rdata", i), rsp_rdata_s, vecs[i].x_rdata);
      check($sformatf("v%0d_error", i), rsp_err_s, vecs[i].x_err);
      check($sformatf("v%0d_rdata_hold", i), o_rsp_rdata, vecs[i].x_rdata);
      check($sformatf("v%0d_error_hold", i), o_rsp_error, vecs[i].x_err);
      check($sformatf("v%0d_starts", i), cmd_starts, vecs[i].x_starts);
      check($sformatf("v%0d_byte0", i), st_byte[0], vecs[i].rg);
      check($sformatf("v%0d_kind0", i), st_kind[0], 0);
      check($sformatf("v%0d_start_lat", i), st_cycle[0], acc_cyc + 1);
      if (vecs[i].x_starts == 2) begin
        check($sformatf("v%0d_kind1", i), st_kind[1], vecs[i].rd);
        check($sformatf("v%0d_start2_lat", i), st_cycle[1], drop_cyc[0] + 1);
        if (!vecs[i].rd) check($sformatf("v%0d_byte1", i), st_byte[1], vecs[i].wd);
      end
      if (vecs[i].nobusy) check($sformatf("v%0d_nobusy_lat", i), rsp_cyc - st_cycle[0], START_WAIT + 2);
      else                check($sformatf("v%0d_rsp_lat", i), rsp_cyc, drop_cyc[cmd_starts-1] + 1);
    end

    // command held valid across a whole transaction, then swapped for a second one
    busy_len = 6;
    err_on   = 0;
    no_busy  = 1'b0;
    rd_data  = 8'h9C;
    n0       = rsp_cnt;
    @(negedge clk);
    wait_ready();
    cmd_starts  = 0;
    i_cmd_valid = 1'b1;
    i_cmd_rd    = 1'b0;
    i_cmd_reg   = 8'h21;
    i_cmd_wdata = 8'h31;
    @(negedge clk);
    i_cmd_rd  = 1'b1;
    i_cmd_reg = 8'h22;
    repeat (4) @(negedge clk);
    check("b2b_ready_low", o_cmd_ready, 0);
    wait_rsp(n0 + 1);
    check("b2b_rsp_a", got_rsp, 1);
    rsp_a = rsp_cyc;
    check("b2b_err_a", rsp_err_s, 0);
    check("b2b_byte_a1", st_byte[1], 8'h31);
    wait_starts(3);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("b2b_start_b_lat", st_cycle[2], rsp_a + 2);
    check("b2b_byte_b", st_byte[2], 8'h22);
    wait_rsp(n0 + 2);
    check("b2b_rsp_b", got_rsp, 1);
    check("b2b_rdata_b", rsp_rdata_s, 8'h9C);
    repeat (3) @(negedge clk);
    check("b2b_rsp_count", rsp_cnt - n0, 2);

    // reset while the read byte is in flight
    busy_len = 30;
    rd_data  = 8'h66;
    n0       = rsp_cnt;
    @(negedge clk);
    wait_ready();
    cmd_starts  = 0;
    i_cmd_valid = 1'b1;
    i_cmd_rd    = 1'b1;
    i_cmd_reg   = 8'h55;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    wait_starts(2);
    repeat (5) @(negedge clk);
    i_rst = 1'b0;
    #1;
    check("mid_rst_ready",    o_cmd_ready,    0);
    check("mid_rst_enable",   o_m_enable,     0);
    check("mid_rst_wr_start", o_m_wr_start,   0);
    check("mid_rst_rd_start", o_m_rd_start,   0);
    check("mid_rst_rsp",      o_rsp_valid,    0);
    check("mid_rst_rdata",    o_rsp_rdata,    0);
    check("mid_rst_error",    o_rsp_error,    0);
    check("mid_rst_wr_byte",  o_m_wr_byte,    0);
    check("mid_rst_addr",     o_m_slave_addr, 7'h50);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_rsp", rsp_cnt - n0, 0);
    check("mid_rst_ready_back", o_cmd_ready, 1);

    busy_len = 4;
    run_cmd(1'b0, 8'h0A, 8'h0B);
    check("post_rst_rsp", got_rsp, 1);
    check("post_rst_err", rsp_err_s, 0);
    check("post_rst_rdata", rsp_rdata_s, 0);
    check("post_rst_starts", cmd_starts, 2);
    check("post_rst_byte0", st_byte[0], 8'h0A);
    check("post_rst_byte1", st_byte[1], 8'h0B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
